fifo_mult_consumer: RTL and testbench
=====================================

Name: fifo_mult_consumer

Overview:
- Downstream consumer of the 16-bit operand FIFO in the multiply datapath.
- Pops operand pairs: multiplicand A first, then multiplier B.
- Computes the unsigned product A*B with a sequential shift-add multiplier, one bit per cycle.
- Presents the 32-bit result with a valid/ack handshake to the next stage.

Parameters:
- WIDTH, 16: operand width; product width is 2*WIDTH.
- DEEP, 4: FIFO depth; used to derive occupancy from Left_Sig.
- CNT_W, 3: width of Left_Sig; must satisfy 2^CNT_W > DEEP.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  reset.
- Left_Sig  in  CNT_W  FIFO free-slot count; occupancy = DEEP - Left_Sig.
- FIFO_Read_Data  in  WIDTH  FIFO registered read data; valid the cycle after a Read_Req cycle.
- Read_Req  out  1  FIFO pop request; high for exactly one cycle per pop.
- Product  out  2*WIDTH  last completed product.
- Product_Valid  out  1  Product holds an unacknowledged result.
- Product_Ack  in  1  downstream accepts Product.
- Busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock (CLK); reset (RST) is asynchronous and active-high.
- Reset effect, including mid-operation:
  - Forces IDLE; Read_Req=0, Product=0, Product_Valid=0, Busy=0.
  - Clears the A, B, accumulator and bit counter.
  - Any partial pop or partial product is discarded. A word already popped from the FIFO is lost; this is accepted.
- State machine states: IDLE, RD_A, RD_B, CAP_B, MULT, DONE.
- Moore outputs:
  - Read_Req=1 only in RD_A and RD_B.
  - Product_Valid=1 only in DONE.
- State transitions:
  - IDLE -> RD_A when occupancy >= 2, i.e. Left_Sig <= DEEP-2. Otherwise stay; Read_Req is never raised with fewer than 2 words present.
  - A Left_Sig value above DEEP is treated as occupancy 0.
  - RD_A -> RD_B unconditionally.
  - RD_B: capture A <= FIFO_Read_Data (A's data is present this cycle); then -> CAP_B.
  - CAP_B: capture B <= FIFO_Read_Data; clear accumulator and counter; then -> MULT.
  - MULT: stays exactly WIDTH cycles, counter 0..WIDTH-1; on counter==WIDTH-1 -> DONE and Product <= final result.
  - DONE: when Product_Ack=1 -> IDLE; otherwise hold.
- MULT arithmetic, per cycle:
  - Compute sum = {1'b0, P_hi} + (B_sh[0] ? A : 0), WIDTH+1 bits.
  - Then {P_hi, B_sh} <= {sum, B_sh} >> 1.
  - After WIDTH cycles, {P_hi, B_sh} equals A*B exactly; no overflow is possible.
- Latency:
  - With the first RD_A cycle as cycle 0, Product_Valid first goes high in cycle WIDTH+3 (cycle 19 at default).
  - Minimum pair-to-pair interval is WIDTH+5 cycles (Ack in the first DONE cycle, IDLE, then RD_A).
- Handshake:
  - Product is stable while Product_Valid=1.
  - Ack in the same cycle Product_Valid rises is legal; Product_Valid drops the next cycle.
  - Product_Ack outside DONE is ignored.
  - Product holds its value after Ack until the next result overwrites it.
- Interaction with the FIFO:
  - The block never pops while Product_Valid=1, so back-pressure holds words in the FIFO.
  - Concurrent upstream writes are tolerated: the FIFO returns the oldest word on a simultaneous read and write.

Decomposition:
- Shared package mult_pkg holds:
  - the state encoding localparams (3-bit);
  - default WIDTH=16 and DEEP=4;
  - a derived PROD_W = 2*WIDTH.
- One sub-module, shift_add_mult_core:
  - Ports: start, A, B, done, product.
  - Owns the accumulator, shifted multiplier and bit counter.
- The top level keeps the pop FSM and the output handshake.

Test Plan:
- Reset check: assert RST asynchronously mid-cycle -> all outputs 0 immediately; FSM in IDLE after release.
- Single pair: FIFO holds 3 then 5 (Left_Sig=2); Ack held high.
  - Read_Req high in cycles 0 and 1 only.
  - Product=0x0000000F with Product_Valid high in cycle 19.
  - Left_Sig returns to 4.
- Occupancy gating: only one word in the FIFO (Left_Sig=3) for 50 cycles -> Read_Req stays 0 and Busy stays 0. Writing a second word starts RD_A the cycle after Left_Sig becomes 2.
- Corner operands: 0xFFFF*0xFFFF -> 0xFFFE0001; 0x0000*0x1234 -> 0x00000000; 0x8000*0x0002 -> 0x00010000.
- Back-pressure: two pairs queued (Left_Sig=0), Ack withheld 10 cycles after the first result.
  - Product and Product_Valid are stable throughout.
  - No Read_Req while waiting.
  - The second pair is popped after Ack and yields the correct product.
- Mid-MULT reset: assert RST at MULT counter=7 -> Product=0 and Product_Valid=0; the next queued pair multiplies correctly after release.

Source files
------------

// File: rtl/fifo_mult_consumer_pkg.sv
// Shared definitions for the FIFO-fed shift-add multiplier: default sizes,
// the 3-bit state encoding and the pop-gating rule.
package mult_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEEP  = 4;
   localparam int PROD_W    = 2 * DEF_WIDTH;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD_A  = 3'd1;
   localparam logic [2:0] S_RD_B  = 3'd2;
   localparam logic [2:0] S_CAP_B = 3'd3;
   localparam logic [2:0] S_MULT  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   typedef enum logic [2:0] {
      IDLE  = S_IDLE,
      RD_A  = S_RD_A,
      RD_B  = S_RD_B,
      CAP_B = S_CAP_B,
      MULT  = S_MULT,
      DONE  = S_DONE
   } state_t;

   // A free-slot count above the depth is nonsense and reads as an empty FIFO.
   function automatic logic can_start(input int left, input int deep);
      return (left <= deep) && ((deep - left) >= 2);
   endfunction

endpackage

// File: rtl/fifo_mult_consumer_if.sv
// FIFO-side and result-side signals of the multiplier consumer, grouped so the
// consumer (master) and its environment (slave) connect through one port.
interface fifo_mult_consumer_if
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 3
);
   logic [CNT_W-1:0]   Left_Sig;
   logic [WIDTH-1:0]   FIFO_Read_Data;
   logic               Read_Req;
   logic [2*WIDTH-1:0] Product;
   logic               Product_Valid;
   logic               Product_Ack;
   logic               Busy;

   modport master (
      input  Left_Sig, FIFO_Read_Data, Product_Ack,
      output Read_Req, Product, Product_Valid, Busy
   );

   modport slave (
      output Left_Sig, FIFO_Read_Data, Product_Ack,
      input  Read_Req, Product, Product_Valid, Busy
   );
endinterface

// File: rtl/fifo_mult_consumer_core.sv
// Sequential shift-add multiplier, one multiplier bit per cycle; done and
// product are valid together in the final iteration cycle.
module shift_add_mult_core
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               start,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0]   p_hi;
   logic [WIDTH-1:0]   b_sh;
   logic [CW-1:0]      cnt;
   logic               active;
   logic [WIDTH:0]     sum;
   logic [2*WIDTH-1:0] shifted;

   // The low bit of b_sh is consumed every cycle, so the shift drops it.
   always_comb begin
      sum     = {1'b0, p_hi} + (b_sh[0] ? {1'b0, A} : '0);
      shifted = {sum, b_sh[WIDTH-1:1]};
   end

   assign done    = active && (cnt == CW'(WIDTH - 1));
   assign product = shifted;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         p_hi   <= '0;
         b_sh   <= '0;
         cnt    <= '0;
         active <= 1'b0;
      end else if (start) begin
         p_hi   <= '0;
         b_sh   <= B;
         cnt    <= '0;
         active <= 1'b1;
      end else if (active) begin
         {p_hi, b_sh} <= shifted;
         cnt          <= cnt + 1'b1;
         if (done)
            active <= 1'b0;
      end
   end

endmodule

// File: rtl/fifo_mult_consumer.sv
// Pops A/B operand pairs from the operand FIFO, multiplies them and holds the
// product under a valid/ack handshake until the next stage accepts it.
module fifo_mult_consumer
   import mult_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEEP  = DEF_DEEP,
   parameter int CNT_W = 3
) (
   input  logic                 CLK,
   input  logic                 RST,
   fifo_mult_consumer_if.master bus
);
   state_t             state;
   logic [WIDTH-1:0]   a_reg;
   logic               start;
   logic               core_done;
   logic [2*WIDTH-1:0] core_product;
   logic               start_ok;

   assign start_ok = can_start(int'(bus.Left_Sig), DEEP);

   // B is only on the FIFO read port during CAP_B, so the core loads it there.
   assign start = (state == CAP_B);

   shift_add_mult_core #(.WIDTH(WIDTH)) u_core (
      .CLK     (CLK),
      .RST     (RST),
      .start   (start),
      .A       (a_reg),
      .B       (bus.FIFO_Read_Data),
      .done    (core_done),
      .product (core_product)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state             <= IDLE;
         a_reg             <= '0;
         bus.Read_Req      <= 1'b0;
         bus.Product       <= '0;
         bus.Product_Valid <= 1'b0;
         bus.Busy          <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start_ok) begin
                  state        <= RD_A;
                  bus.Read_Req <= 1'b1;
                  bus.Busy     <= 1'b1;
               end
            end
            RD_A: begin
               state        <= RD_B;
               bus.Read_Req <= 1'b1;
            end
            RD_B: begin
               a_reg        <= bus.FIFO_Read_Data;
               state        <= CAP_B;
               bus.Read_Req <= 1'b0;
            end
            CAP_B: begin
               state <= MULT;
            end
            MULT: begin
               if (core_done) begin
                  state             <= DONE;
                  bus.Product       <= core_product;
                  bus.Product_Valid <= 1'b1;
               end
            end
            DONE: begin
               if (bus.Product_Ack) begin
                  state             <= IDLE;
                  bus.Product_Valid <= 1'b0;
                  bus.Busy          <= 1'b0;
               end
            end
            default: begin
               state             <= IDLE;
               bus.Read_Req      <= 1'b0;
               bus.Product_Valid <= 1'b0;
               bus.Busy          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_mult_consumer.sv
// Bench for fifo_mult_consumer: a queue-based FIFO feeds operand pairs and
// products are compared against plain arithmetic with fixed-latency rules.
module tb_fifo_mult_consumer;
   import mult_pkg::*;

   localparam int WIDTH = 16;
   localparam int DEEP  = 4;
   localparam int CNT_W = 3;
   localparam int LAT   = WIDTH + 3;
   localparam int NRAND = 24;

   logic CLK = 1'b0;
   logic RST;
   int   checks = 0;
   int   errors = 0;

   logic [WIDTH-1:0]   fq[$];
   logic [WIDTH-1:0]   pend[$];
   logic [2*WIDTH-1:0] exp_q[$];

   fifo_mult_consumer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

   fifo_mult_consumer #(.WIDTH(WIDTH), .DEEP(DEEP), .CNT_W(CNT_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*WIDTH-1:0] mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (2*WIDTH)'(a) * (2*WIDTH)'(b);
   endfunction

   task automatic push(input logic [WIDTH-1:0] w);
      fq.push_back(w);
      bus.Left_Sig = CNT_W'(DEEP - fq.size());
   endtask

   // One clock: a pop requested before the edge returns the oldest word after it.
   task automatic step();
      logic pop;
      pop = bus.Read_Req;
      @(posedge CLK);
      #1;
      if (pop) begin
         chk("fifo_not_empty_on_pop", 64'(fq.size() != 0), 64'(1));
         if (fq.size() != 0)
            bus.FIFO_Read_Data = fq.pop_front();
      end
      bus.Left_Sig = CNT_W'(DEEP - fq.size());
   endtask

   task automatic run_pair(input string tag, input logic [2*WIDTH-1:0] expv);
      int   n;
      logic ok_rr;
      logic ok_pv;
      n = 0;
      while (bus.Read_Req !== 1'b1 && n < 40) begin
         step();
         n++;
      end
      chk({tag, "_start"}, 64'(bus.Read_Req), 64'(1));
      ok_rr = 1'b1;
      ok_pv = 1'b1;
      for (int k = 1; k <= LAT; k++) begin
         step();
         if (bus.Read_Req !== (k == 1))
            ok_rr = 1'b0;
         if (bus.Product_Valid !== (k == LAT))
            ok_pv = 1'b0;
      end
      chk({tag, "_read_req_window"}, 64'(ok_rr), 64'(1));
      chk({tag, "_valid_latency"}, 64'(ok_pv), 64'(1));
      chk({tag, "_product"}, 64'(bus.Product), 64'(expv));
   endtask

   initial begin
      logic               ok;
      logic [2*WIDTH-1:0] held;
      logic [WIDTH-1:0]   a;
      logic [WIDTH-1:0]   b;
      logic               pv;
      logic               ack;
      logic               rr_before;
      logic [CNT_W-1:0]   left_before;
      logic               rr_ok;
      logic               gate_ok;
      logic               stable_ok;
      logic [2*WIDTH-1:0] prev_prod;
      logic [2*WIDTH-1:0] expv;
      int                 consumed;
      int                 n;

      RST                = 1'b1;
      bus.Left_Sig       = CNT_W'(DEEP);
      bus.FIFO_Read_Data = '0;
      bus.Product_Ack    = 1'b0;
      @(posedge CLK);
      #1;
      chk("reset_read_req", 64'(bus.Read_Req), 64'(0));
      chk("reset_product", 64'(bus.Product), 64'(0));
      chk("reset_valid", 64'(bus.Product_Valid), 64'(0));
      chk("reset_busy", 64'(bus.Busy), 64'(0));
      RST = 1'b0;
      step();
      chk("idle_empty_busy", 64'(bus.Busy), 64'(0));

      // Single pair, Ack held high
      bus.Product_Ack = 1'b1;
      push(16'd3);
      push(16'd5);
      run_pair("single", 32'h0000_000F);
      step();
      chk("single_valid_drops", 64'(bus.Product_Valid), 64'(0));
      chk("single_product_held", 64'(bus.Product), 64'h0000_000F);
      chk("single_busy_idle", 64'(bus.Busy), 64'(0));
      chk("single_left_sig", 64'(bus.Left_Sig), 64'(DEEP));

      // One word only: no pop may start
      push(16'h0011);
      gate_ok = 1'b1;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.Read_Req !== 1'b0 || bus.Busy !== 1'b0)
            gate_ok = 1'b0;
      end
      chk("gate_one_word_idle", 64'(gate_ok), 64'(1));
      push(16'h0013);
      step();
      chk("gate_starts_next_cycle", 64'(bus.Read_Req), 64'(1));
      run_pair("gate_pair", mul(16'h0011, 16'h0013));

      // Corner operands
      push(16'hFFFF); push(16'hFFFF);
      run_pair("corner_ffff", 32'hFFFE_0001);
      push(16'h0000); push(16'h1234);
      run_pair("corner_zero", 32'h0000_0000);
      push(16'h8000); push(16'h0002);
      run_pair("corner_msb", 32'h0001_0000);
      step();

      // Back-pressure with two pairs queued
      bus.Product_Ack = 1'b0;
      push(16'hABCD); push(16'h0003);
      push(16'h0102); push(16'h0304);
      chk("bp_fifo_full", 64'(bus.Left_Sig), 64'(0));
      run_pair("bp_first", mul(16'hABCD, 16'h0003));
      held      = bus.Product;
      stable_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (bus.Product !== held || bus.Product_Valid !== 1'b1 || bus.Read_Req !== 1'b0)
            stable_ok = 1'b0;
      end
      chk("bp_hold_stable", 64'(stable_ok), 64'(1));
      chk("bp_second_pair_kept", 64'(bus.Left_Sig), 64'(DEEP - 2));
      bus.Product_Ack = 1'b1;
      step();
      bus.Product_Ack = 1'b0;
      chk("bp_valid_drops_after_ack", 64'(bus.Product_Valid), 64'(0));
      run_pair("bp_second", mul(16'h0102, 16'h0304));
      bus.Product_Ack = 1'b1;
      step();
      chk("bp_second_acked", 64'(bus.Product_Valid), 64'(0));

      // Free-slot counts above the depth read as empty
      gate_ok = 1'b1;
      for (int v = DEEP + 1; v < (1 << CNT_W); v++) begin
         bus.Left_Sig = CNT_W'(v);
         for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            #1;
            if (bus.Read_Req !== 1'b0 || bus.Busy !== 1'b0)
               gate_ok = 1'b0;
         end
      end
      bus.Left_Sig = CNT_W'(DEEP - fq.size());
      chk("left_above_deep_idle", 64'(gate_ok), 64'(1));

      // Asynchronous reset in the middle of MULT
      push(16'h0007); push(16'h0009);
      push(16'h1234); push(16'h0101);
      n = 0;
      while (bus.Read_Req !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      for (int i = 0; i < 10; i++)
         step();
      chk("mid_busy_before_reset", 64'(bus.Busy), 64'(1));
      #2;
      RST = 1'b1;
      #1;
      chk("mid_rst_read_req", 64'(bus.Read_Req), 64'(0));
      chk("mid_rst_product", 64'(bus.Product), 64'(0));
      chk("mid_rst_valid", 64'(bus.Product_Valid), 64'(0));
      chk("mid_rst_busy", 64'(bus.Busy), 64'(0));
      step();
      chk("mid_rst_held_valid", 64'(bus.Product_Valid), 64'(0));
      RST = 1'b0;
      run_pair("after_rst", mul(16'h1234, 16'h0101));
      step();

      // Randomized pairs with random upstream timing and random Ack
      for (int i = 0; i < NRAND; i++) begin
         a = WIDTH'($urandom);
         b = WIDTH'($urandom);
         if (i == 0) a = '1;
         pend.push_back(a);
         pend.push_back(b);
         exp_q.push_back(mul(a, b));
      end
      consumed  = 0;
      n         = 0;
      rr_ok     = 1'b1;
      stable_ok = 1'b1;
      prev_prod = bus.Product;
      while (consumed < NRAND && n < 8000) begin
         if (pend.size() != 0 && fq.size() < DEEP && $urandom_range(0, 2) != 0)
            push(pend.pop_front());
         bus.Product_Ack = ($urandom_range(0, 3) == 0);
         pv          = bus.Product_Valid;
         ack         = bus.Product_Ack;
         rr_before   = bus.Read_Req;
         left_before = bus.Left_Sig;
         step();
         n++;
         if (pv && ack)
            consumed++;
         if (bus.Read_Req && !rr_before && int'(left_before) > DEEP - 2)
            rr_ok = 1'b0;
         if (bus.Read_Req && bus.Product_Valid)
            rr_ok = 1'b0;
         if (bus.Product_Valid && !pv) begin
            expv = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            chk("rand_product", 64'(bus.Product), 64'(expv));
         end else if (bus.Product_Valid && pv && bus.Product !== prev_prod) begin
            stable_ok = 1'b0;
         end
         prev_prod = bus.Product;
      end
      chk("rand_all_consumed", 64'(consumed), 64'(NRAND));
      chk("rand_no_leftover", 64'(exp_q.size()), 64'(0));
      chk("rand_pop_rules", 64'(rr_ok), 64'(1));
      chk("rand_product_stable", 64'(stable_ok), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
